// File: rtl/lv2_bus_responder_il_if.sv
// lv1-lv2 instruction-fetch bus plus the L2 array handshake, as seen by the L2 responder.
// The responder connects through the slave modport. The master modport is the L1 and array side.
interface lv2_bus_responder_il_if #(
  parameter int NUM_PROC = 4,
  parameter int ADDR_WID = 32,
  parameter int DATA_WID = 32
);
  logic [NUM_PROC-1:0] bus_lv1_lv2_req_proc_il;
  logic [NUM_PROC-1:0] bus_lv1_lv2_gnt_proc;
  logic [ADDR_WID-1:0] addr_bus_lv1_lv2;
  logic                lv2_rd;
  logic [DATA_WID-1:0] data_bus_lv1_lv2;
  logic                data_in_bus_lv1_lv2;
  logic                lv2_arr_rd;
  logic [ADDR_WID-1:0] lv2_arr_addr;
  logic [DATA_WID-1:0] lv2_arr_data;
  logic                lv2_arr_ack;

  modport slave (
    input  bus_lv1_lv2_req_proc_il, addr_bus_lv1_lv2, lv2_rd, lv2_arr_data, lv2_arr_ack,
    output bus_lv1_lv2_gnt_proc, data_bus_lv1_lv2, data_in_bus_lv1_lv2, lv2_arr_rd, lv2_arr_addr
  );

  modport master (
    output bus_lv1_lv2_req_proc_il, addr_bus_lv1_lv2, lv2_rd, lv2_arr_data, lv2_arr_ack,
    input  bus_lv1_lv2_gnt_proc, data_bus_lv1_lv2, data_in_bus_lv1_lv2, lv2_arr_rd, lv2_arr_addr
  );
endinterface

// File: rtl/lv2_bus_responder_il.sv
// L2 responder for the lv1-lv2 IL bus: round-robin grant, one array fetch per grant, response hold.
// Optional macro LV2_RESP_TIMEOUT_EN revokes a grant that stays idle for TIMEOUT_CYC cycles.
module lv2_bus_responder_il #(
  parameter int NUM_PROC    = 4,
  parameter int PROC_WID    = 2,
  parameter int ADDR_WID    = 32,
  parameter int DATA_WID    = 32,
  parameter int TIMEOUT_CYC = 16,
  parameter int TIMEOUT_WID = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  lv2_bus_responder_il_if.slave bus
);

  typedef enum logic [1:0] {IDLE, GRANT, FETCH, RESP} state_e;

  state_e              state_q;
  logic [PROC_WID-1:0] last_q;
  logic [PROC_WID-1:0] win_d;
  logic [NUM_PROC-1:0] gnt_q;
  logic [DATA_WID-1:0] data_q;
  logic                data_in_q;
  logic                arr_rd_q;
  logic [ADDR_WID-1:0] arr_addr_q;
  logic                cur_req;

`ifdef LV2_RESP_TIMEOUT_EN
  logic [TIMEOUT_WID-1:0] tmo_q;
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = ^{TIMEOUT_CYC, TIMEOUT_WID};
`endif

  function automatic logic [NUM_PROC-1:0] onehot(input logic [PROC_WID-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

  // Once granted, last_q doubles as the index of the core that owns the bus.
  assign cur_req = bus.bus_lv1_lv2_req_proc_il[last_q];

  // Search downward so the nearest requester after last_q is written last and wins.
  always_comb begin
    logic [PROC_WID-1:0] idx;
    idx   = '0;
    win_d = last_q;
    for (int k = NUM_PROC; k >= 1; k--) begin
      idx = PROC_WID'((int'(last_q) + k) % NUM_PROC);
      if (bus.bus_lv1_lv2_req_proc_il[idx]) win_d = idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      last_q     <= PROC_WID'(NUM_PROC - 1);
      gnt_q      <= '0;
      data_q     <= '0;
      data_in_q  <= 1'b0;
      arr_rd_q   <= 1'b0;
      arr_addr_q <= '0;
`ifdef LV2_RESP_TIMEOUT_EN
      tmo_q      <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (|bus.bus_lv1_lv2_req_proc_il) begin
            state_q <= GRANT;
            gnt_q   <= onehot(win_d);
            last_q  <= win_d;
`ifdef LV2_RESP_TIMEOUT_EN
            tmo_q   <= '0;
`endif
          end
        end
        GRANT: begin
          if (bus.lv2_rd) begin
            arr_addr_q <= bus.addr_bus_lv1_lv2;
            arr_rd_q   <= 1'b1;
            state_q    <= FETCH;
          end else if (!cur_req) begin
            gnt_q   <= '0;
            state_q <= IDLE;
          end
`ifdef LV2_RESP_TIMEOUT_EN
          // last_q keeps the revoked core so the search starts after it.
          else if (tmo_q + TIMEOUT_WID'(1) == TIMEOUT_WID'(TIMEOUT_CYC)) begin
            gnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            tmo_q <= tmo_q + TIMEOUT_WID'(1);
          end
`endif
        end
        FETCH: begin
          if (bus.lv2_arr_ack) begin
            data_q    <= bus.lv2_arr_data;
            data_in_q <= 1'b1;
            arr_rd_q  <= 1'b0;
            state_q   <= RESP;
          end
        end
        RESP: begin
          if (!bus.lv2_rd || !cur_req) begin
            data_q     <= '0;
            data_in_q  <= 1'b0;
            gnt_q      <= '0;
            arr_addr_q <= '0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.bus_lv1_lv2_gnt_proc = gnt_q;
  assign bus.data_bus_lv1_lv2     = data_q;
  assign bus.data_in_bus_lv1_lv2  = data_in_q;
  assign bus.lv2_arr_rd           = arr_rd_q;
  assign bus.lv2_arr_addr         = arr_addr_q;

endmodule
